// File: rtl/i2c_pkg.sv
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types and constants for the I2C command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    // Sequencer FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_ARM     = 3'd2,
        ST_BUSY    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_GAP     = 3'd5
    } seq_state_t;

    // Response entry: {err, is_read, data[31:0]}
    localparam int RSP_W = 34;
    // Command entry: {ctrl[31:0], wdata[31:0]}
    localparam int CMD_W = 64;

    localparam int START_TMO_DEF = 64;
    localparam int DONE_TMO_DEF  = 1 << 20;

endpackage

`default_nettype wire

// File: rtl/i2c_cmd_sequencer_if.sv
// ============================================================================
//  Module      : i2c_cmd_sequencer_if
//  Description : Host-side command / response handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_cmd_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_ctrl;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_is_read;
    logic        rsp_err;

    // Host (register block) side
    modport master (
        output cmd_valid, cmd_ctrl, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_is_read, rsp_err
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_ctrl, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_is_read, rsp_err
    );

endinterface

`default_nettype wire

// File: rtl/i2c_sync_fifo.sv
// ============================================================================
//  Module      : i2c_sync_fifo
//  Description : First-word-fall-through synchronous FIFO with level output.
//                Head data reads as zero while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  wire logic                     aclk,
    input  wire logic                     areset,
    input  wire logic                     wr_en,
    input  wire logic [WIDTH-1:0]         wr_data,
    output logic                          full,
    input  wire logic                     rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    // Extra pointer MSB distinguishes full from empty when low bits match
    assign full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign level   = r_wr_ptr - r_rd_ptr;
    assign w_push  = wr_en & ~full;
    assign w_pop   = rd_en & ~empty;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

    // Storage array, written on accepted pushes only
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointers, wrapping naturally modulo 2*DEPTH
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
// ============================================================================
//  Module      : i2c_cmd_sequencer
//  Description : Queues {ctrl, wdata} commands, launches them one at a time on
//                the I2C master and queues {err, is_read, rdata} responses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int RW_BIT    = 0,
    parameter int START_TMO = START_TMO_DEF,
    parameter int DONE_TMO  = DONE_TMO_DEF
) (
    input  wire logic                       aclk,
    input  wire logic                       areset,
    i2c_cmd_sequencer_if.slave              host,
    output logic [31:0]                     i2c_ctrl,
    output logic [31:0]                     wdata,
    output logic                            i2c_start,
    input  wire logic [31:0]                rdata,
    input  wire logic                       i2c_idle,
    output logic                            seq_busy,
    output logic [$clog2(CMD_DEPTH):0]      cmd_level
);

    localparam int              c_TW        = $clog2(DONE_TMO) + 1;
    localparam logic [c_TW-1:0] c_START_LIM = c_TW'(START_TMO);
    localparam logic [c_TW-1:0] c_DONE_LIM  = c_TW'(DONE_TMO);

    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic [c_TW-1:0]        r_timer;
    logic                   r_err;
    logic                   r_is_read;
    logic [31:0]            r_i2c_ctrl;
    logic [31:0]            r_wdata;

    logic                   w_cmd_pop;
    logic                   w_cmd_full;
    logic                   w_cmd_empty;
    logic [CMD_W-1:0]       w_cmd_head;
    logic                   w_rsp_push;
    logic                   w_rsp_full;
    logic                   w_rsp_empty;
    logic [RSP_W-1:0]       w_rsp_din;
    logic [RSP_W-1:0]       w_rsp_head;
    logic [$clog2(RSP_DEPTH):0] w_rsp_level;
    logic                   w_timer_clr;
    logic                   w_err_set;

    i2c_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .wr_en   (host.cmd_valid),
        .wr_data ({host.cmd_ctrl, host.cmd_wdata}),
        .full    (w_cmd_full),
        .rd_en   (w_cmd_pop),
        .rd_data (w_cmd_head),
        .empty   (w_cmd_empty),
        .level   (cmd_level)
    );

    // Read data is only meaningful for reads that completed without timeout
    assign w_rsp_din = {r_err, r_is_read, (r_is_read && !r_err) ? rdata : 32'h0};

    i2c_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .wr_en   (w_rsp_push),
        .wr_data (w_rsp_din),
        .full    (w_rsp_full),
        .rd_en   (host.rsp_ready),
        .rd_data (w_rsp_head),
        .empty   (w_rsp_empty),
        .level   (w_rsp_level)
    );

    assign host.cmd_ready   = ~w_cmd_full;
    assign host.rsp_valid   = ~w_rsp_empty;
    assign host.rsp_err     = w_rsp_head[33];
    assign host.rsp_is_read = w_rsp_head[32];
    assign host.rsp_rdata   = w_rsp_head[31:0];

    assign i2c_ctrl  = r_i2c_ctrl;
    assign wdata     = r_wdata;
    assign i2c_start = (r_state == ST_LAUNCH);
    assign seq_busy  = (r_state != ST_IDLE) || !w_cmd_empty;

    // FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode and per-state control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_pop   = 1'b0;
        w_rsp_push  = 1'b0;
        w_timer_clr = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A master that is already busy is left alone
                if (!w_cmd_empty && i2c_idle) begin
                    w_cmd_pop   = 1'b1;
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_timer_clr = 1'b1;
                w_state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (!i2c_idle) begin
                    w_timer_clr = 1'b1;
                    w_state_nxt = ST_BUSY;
                end else if (r_timer >= c_START_LIM) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_BUSY: begin
                if (i2c_idle) begin
                    w_state_nxt = ST_CAPTURE;
                end else if (r_timer >= c_DONE_LIM) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!w_rsp_full) begin
                    w_rsp_push  = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Saturating timeout timer for ARM and BUSY
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_timer <= '0;
        end else if (w_timer_clr) begin
            r_timer <= '0;
        end else if ((r_state == ST_ARM || r_state == ST_BUSY) && (r_timer != '1)) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Command registers to the master and per-transaction status flags
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_i2c_ctrl <= '0;
            r_wdata    <= '0;
            r_is_read  <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_cmd_pop) begin
            r_i2c_ctrl <= w_cmd_head[63:32];
            r_wdata    <= w_cmd_head[31:0];
            r_is_read  <= w_cmd_head[32 + RW_BIT];
            r_err      <= 1'b0;
        end else if (w_err_set) begin
            r_err      <= 1'b1;
        end
    end

    // Response occupancy can never exceed the configured depth
    a_rsp_level: assert property (@(posedge aclk) disable iff (areset)
        w_rsp_level <= ($clog2(RSP_DEPTH)+1)'(RSP_DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
// ============================================================================
//  Module      : tb_i2c_cmd_sequencer
//  Description : Directed self-checking bench with a behavioural I2C master.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_cmd_sequencer;

    logic        aclk   = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] i2c_ctrl;
    logic [31:0] wdata;
    logic        i2c_start;
    logic [31:0] rdata    = 32'h0;
    logic        i2c_idle = 1'b1;
    logic        seq_busy;
    logic [2:0]  cmd_level;

    int n_checks = 0;
    int n_pass   = 0;

    // Master model knobs and observation log
    int          mdl_delay  = 3;
    int          mdl_hold   = 100;
    bit          mdl_ignore = 1'b0;
    bit          mdl_echo   = 1'b0;
    logic [31:0] mdl_rdata  = 32'h0;
    int          start_cnt  = 0;
    logic [31:0] start_ctrl [$];
    logic [31:0] start_wdata [$];
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic [31:0] m_ctrl  = 32'h0;

    i2c_cmd_sequencer_if bus();

    i2c_cmd_sequencer #(
        .CMD_DEPTH (4),
        .RSP_DEPTH (4),
        .RW_BIT    (0),
        .START_TMO (64),
        .DONE_TMO  (1 << 20)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .host      (bus.slave),
        .i2c_ctrl  (i2c_ctrl),
        .wdata     (wdata),
        .i2c_start (i2c_start),
        .rdata     (rdata),
        .i2c_idle  (i2c_idle),
        .seq_busy  (seq_busy),
        .cmd_level (cmd_level)
    );

    always #5 aclk = ~aclk;

    // Behavioural master: acts 2ns after each rising edge
    always @(posedge aclk) begin
        #2;
        if (areset) begin
            m_phase  = 0;
            m_cnt    = 0;
            i2c_idle = 1'b1;
        end else begin
            case (m_phase)
                0: if (i2c_start) begin
                    start_cnt++;
                    start_ctrl.push_back(i2c_ctrl);
                    start_wdata.push_back(wdata);
                    m_ctrl = i2c_ctrl;
                    if (!mdl_ignore) begin m_phase = 1; m_cnt = 0; end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt >= mdl_delay) begin i2c_idle = 1'b0; m_phase = 2; m_cnt = 0; end
                end
                default: begin
                    m_cnt++;
                    if (m_cnt >= mdl_hold) begin
                        i2c_idle = 1'b1;
                        rdata    = mdl_echo ? {16'hBEEF, m_ctrl[15:0]} : mdl_rdata;
                        m_phase  = 0;
                    end
                end
            endcase
        end
    end

    task automatic push_cmd(input logic [31:0] c, input logic [31:0] w, output bit ok);
        bus.cmd_ctrl  = c;
        bus.cmd_wdata = w;
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int g = 0; g < 2000; g++) begin
            if (bus.cmd_ready) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        @(negedge aclk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int tmo, output bit ok);
        ok = 1'b0;
        for (int g = 0; g < tmo; g++) begin
            if (bus.rsp_valid) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
    endtask

    task automatic wait_starts(input int n, input int tmo, output bit ok);
        ok = 1'b0;
        for (int g = 0; g < tmo; g++) begin
            if (start_cnt >= n) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
    endtask

    task automatic pop_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge aclk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        n_checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_is_read, i2c_start, seq_busy} !== 6'b100000) begin
            $display("FAIL reset_flags got=%b exp=100000", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_is_read, i2c_start, seq_busy});
        end else n_pass++;
        n_checks++;
        if ({i2c_ctrl, wdata, bus.rsp_rdata} !== 96'h0) begin
            $display("FAIL reset_data got=%h exp=0", {i2c_ctrl, wdata, bus.rsp_rdata});
        end else n_pass++;
        n_checks++;
        if (cmd_level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", cmd_level);
        else n_pass++;
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_single_write();
        bit ok;
        int base = start_cnt;
        int k;
        mdl_delay = 3; mdl_hold = 100; mdl_echo = 1'b0; mdl_rdata = 32'hDEAD_BEEF;
        push_cmd(32'h0000_A050, 32'h0000_005A, ok);
        wait_starts(base + 1, 50, ok);
        n_checks++;
        if (!ok) $display("FAIL wr_start got=%0d exp=%0d", start_cnt - base, 1);
        else n_pass++;
        n_checks++;
        if ({start_ctrl[base], start_wdata[base]} !== {32'h0000_A050, 32'h0000_005A}) begin
            $display("FAIL wr_ctrl got=%h_%h exp=0000a050_0000005a", start_ctrl[base], start_wdata[base]);
        end else n_pass++;
        for (int g = 0; g < 50 && i2c_idle; g++) @(negedge aclk);
        for (int g = 0; g < 200 && !i2c_idle; g++) @(negedge aclk);
        k = 0;
        while (!bus.rsp_valid && k < 20) begin @(negedge aclk); k++; end
        n_checks++;
        if (k !== 2) $display("FAIL wr_rsp_latency got=%0d exp=2", k);
        else n_pass++;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata} !== {3'b100, 32'h0}) begin
            $display("FAIL wr_rsp got=%b%b%b_%h exp=100_00000000", bus.rsp_valid, bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata);
        end else n_pass++;
        pop_rsp();
        n_checks++;
        if ({bus.rsp_valid, start_cnt - base} !== {1'b0, 32'd1}) begin
            $display("FAIL wr_after rsp_valid=%b starts=%0d exp=0/1", bus.rsp_valid, start_cnt - base);
        end else n_pass++;
    endtask

    task automatic test_single_read();
        bit ok;
        mdl_hold = 10; mdl_rdata = 32'h0000_00C3;
        push_cmd(32'h0000_A051, 32'h0, ok);
        wait_rsp(300, ok);
        n_checks++;
        if (!ok || {bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata} !== {2'b01, 32'h0000_00C3}) begin
            $display("FAIL rd_rsp got=%b%b_%h exp=01_000000c3", bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata);
        end else n_pass++;
        pop_rsp();
    endtask

    task automatic test_burst();
        bit ok;
        int base = start_cnt;
        logic [31:0] ctrls [5] = '{32'hB000_0010, 32'hB000_0021, 32'hB000_0032, 32'hB000_0043, 32'hB000_0054};
        logic [33:0] exp;
        mdl_hold = 30; mdl_echo = 1'b1;
        push_cmd(ctrls[0], 32'd0, ok);
        wait_starts(base + 1, 50, ok);
        for (int i = 1; i < 5; i++) push_cmd(ctrls[i], 32'(i), ok);
        n_checks++;
        if ({bus.cmd_ready, cmd_level} !== {1'b0, 3'd4}) begin
            $display("FAIL burst_full ready=%b level=%0d exp=0/4", bus.cmd_ready, cmd_level);
        end else n_pass++;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(500, ok);
            exp = {1'b0, ctrls[i][0], ctrls[i][0] ? {16'hBEEF, ctrls[i][15:0]} : 32'h0};
            n_checks++;
            if (!ok || {bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata} !== exp) begin
                $display("FAIL burst_rsp%0d got=%b%b_%h exp=%h", i, bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata, exp);
            end else n_pass++;
            pop_rsp();
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({start_ctrl[base+i], start_wdata[base+i]} !== {ctrls[i], 32'(i)}) begin
                $display("FAIL burst_ctrl%0d got=%h_%h exp=%h_%h", i, start_ctrl[base+i], start_wdata[base+i], ctrls[i], 32'(i));
            end else n_pass++;
        end
    endtask

    task automatic test_start_tmo();
        bit ok;
        int base = start_cnt;
        mdl_hold = 10; mdl_ignore = 1'b1;
        push_cmd(32'h0000_0071, 32'h0, ok);
        push_cmd(32'h0000_0080, 32'h0, ok);
        wait_starts(base + 1, 50, ok);
        mdl_ignore = 1'b0;
        wait_rsp(300, ok);
        n_checks++;
        if (!ok || {bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata} !== {2'b11, 32'h0}) begin
            $display("FAIL tmo_rsp got=%b%b_%h exp=11_00000000", bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata);
        end else n_pass++;
        pop_rsp();
        wait_starts(base + 2, 50, ok);
        n_checks++;
        if (!ok || start_ctrl[base+1] !== 32'h0000_0080) begin
            $display("FAIL tmo_next_start starts=%0d exp=2", start_cnt - base);
        end else n_pass++;
        wait_rsp(300, ok);
        n_checks++;
        if (!ok || {bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata} !== {2'b00, 32'h0}) begin
            $display("FAIL tmo_next_rsp got=%b%b_%h exp=00_00000000", bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata);
        end else n_pass++;
        pop_rsp();
    endtask

    task automatic test_backpressure();
        bit ok;
        int base = start_cnt;
        logic [31:0] c;
        mdl_hold = 5; mdl_echo = 1'b1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(32'h0000_0101 + 32'(2*i), 32'h0, ok);
        repeat (300) @(negedge aclk);
        n_checks++;
        if ({start_cnt - base, bus.rsp_valid, seq_busy, cmd_level} !== {32'd5, 1'b1, 1'b1, 3'd0}) begin
            $display("FAIL bp_stall starts=%0d rsp_valid=%b busy=%b level=%0d exp=5/1/1/0", start_cnt - base, bus.rsp_valid, seq_busy, cmd_level);
        end else n_pass++;
        for (int i = 0; i < 5; i++) begin
            c = 32'h0000_0101 + 32'(2*i);
            wait_rsp(50, ok);
            n_checks++;
            if (!ok || {bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata} !== {2'b01, 16'hBEEF, c[15:0]}) begin
                $display("FAIL bp_rsp%0d got=%b%b_%h exp=01_beef%h", i, bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata, c[15:0]);
            end else n_pass++;
            pop_rsp();
        end
        repeat (20) @(negedge aclk);
        n_checks++;
        if ({bus.rsp_valid, start_cnt - base} !== {1'b0, 32'd5}) begin
            $display("FAIL bp_drained rsp_valid=%b starts=%0d exp=0/5", bus.rsp_valid, start_cnt - base);
        end else n_pass++;
    endtask

    task automatic test_reset_busy();
        bit ok;
        int base;
        mdl_hold = 200; mdl_echo = 1'b0;
        push_cmd(32'h0000_0C00, 32'h11, ok);
        push_cmd(32'h0000_0D00, 32'h22, ok);
        for (int g = 0; g < 50 && i2c_idle; g++) @(negedge aclk);
        repeat (5) @(negedge aclk);
        n_checks++;
        if ({i2c_idle, cmd_level, seq_busy} !== {1'b0, 3'd1, 1'b1}) begin
            $display("FAIL rstb_pre idle=%b level=%0d busy=%b exp=0/1/1", i2c_idle, cmd_level, seq_busy);
        end else n_pass++;
        areset = 1'b1;
        #1;
        n_checks++;
        if ({bus.cmd_ready, bus.rsp_valid, i2c_start, seq_busy, cmd_level} !== {4'b1000, 3'd0}) begin
            $display("FAIL rstb_flags got=%b_%0d exp=1000_0", {bus.cmd_ready, bus.rsp_valid, i2c_start, seq_busy}, cmd_level);
        end else n_pass++;
        n_checks++;
        if ({i2c_ctrl, wdata} !== 64'h0) $display("FAIL rstb_regs got=%h exp=0", {i2c_ctrl, wdata});
        else n_pass++;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        base = start_cnt;
        mdl_hold = 10; mdl_echo = 1'b1;
        push_cmd(32'h0000_00A1, 32'h0, ok);
        wait_rsp(300, ok);
        n_checks++;
        if (!ok || {bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata} !== {2'b01, 32'hBEEF_00A1} || start_cnt - base != 1) begin
            $display("FAIL rstb_fresh got=%b%b_%h starts=%0d exp=01_beef00a1/1", bus.rsp_err, bus.rsp_is_read, bus.rsp_rdata, start_cnt - base);
        end else n_pass++;
        pop_rsp();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_ctrl  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single_write();
        test_single_read();
        test_burst();
        test_start_tmo();
        test_backpressure();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
